// File: rtl/pmod_gpio_pkg.sv
// Shared constants and helpers for the Pmod GPIO sampler.
// Holds the pin counts and the debounce counter width function used when
// PMOD_GPIO_SAMPLER_DEBOUNCE_EN is defined.
package pmod_gpio_pkg;

  localparam int ROW_PINS  = 4;
  localparam int PMOD_PINS = 8;

  // Counter must hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    if (n <= 32'sd2) begin
      w = 32'sd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/pmod_gpio_debounce.sv
// Single-pin conditioner: synchronizer chain, optional debounce counter,
// stable level register and registered rise/fall pulses.
// Macro PMOD_GPIO_SAMPLER_DEBOUNCE_EN selects the counter-based debounce;
// without it the stable level simply follows the synchronized level.
module pmod_gpio_debounce
  import pmod_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PMOD_GPIO_SAMPLER_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 1000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_stable_nxt;
  logic                   w_change;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

`ifdef PMOD_GPIO_SAMPLER_DEBOUNCE_EN
  localparam int                 CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Count while synchronized and stable levels differ; accept at CNT_LAST.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_change     = 1'b0;
    if (w_sync == r_stable) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_nxt    = {CNT_W{1'b0}};
      w_stable_nxt = w_sync;
      w_change     = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  // Without debounce the stable level tracks the synchronizer every cycle.
  always_comb begin
    w_stable_nxt = w_sync;
    w_change     = w_sync ^ r_stable;
  end
`endif

  // Stable level plus one-cycle edge pulses aligned with its update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_stable <= w_stable_nxt;
      r_rise   <= w_change & w_stable_nxt;
      r_fall   <= w_change & ~w_stable_nxt;
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/pmod_gpio_sampler.sv
// Pmod GPIO sampler top: conditions 8 bridge pins into debounced levels for
// AXI GPIO and collects masked sticky edge events with an OR-reduced irq.
// Optional macro: PMOD_GPIO_SAMPLER_DEBOUNCE_EN (counter-based debounce).
module pmod_gpio_sampler
  import pmod_gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROW_PINS-1:0]  top_tri_i,
  input  logic [ROW_PINS-1:0]  bottom_tri_i,
  output logic [PMOD_PINS-1:0] gpio_tri_i,
  input  logic [PMOD_PINS-1:0] rise_mask,
  input  logic [PMOD_PINS-1:0] fall_mask,
  input  logic [PMOD_PINS-1:0] event_clr,
  output logic [PMOD_PINS-1:0] event_o,
  output logic                 irq
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("pmod_gpio_sampler: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [PMOD_PINS-1:0] w_pins;
  logic [PMOD_PINS-1:0] w_level;
  logic [PMOD_PINS-1:0] w_rise;
  logic [PMOD_PINS-1:0] w_fall;
  logic [PMOD_PINS-1:0] w_event_nxt;
  logic [PMOD_PINS-1:0] r_event;

  assign w_pins = {bottom_tri_i, top_tri_i};

  for (genvar g = 0; g < PMOD_PINS; g++) begin : g_pin
    pmod_gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES)
`ifdef PMOD_GPIO_SAMPLER_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_pin   (w_pins[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  // Sticky events: clear by pulse, masked edge pulses set; set wins.
  always_comb begin
    w_event_nxt = (r_event & ~event_clr) | (w_rise & rise_mask) | (w_fall & fall_mask);
  end

  // Event flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_event <= {PMOD_PINS{1'b0}};
    end else begin
      r_event <= w_event_nxt;
    end
  end

  assign gpio_tri_i = w_level;
  assign event_o    = r_event;
  assign irq        = |r_event;

endmodule

// File: tb/tb_pmod_gpio_sampler.sv
// Directed, table-driven bench for pmod_gpio_sampler (SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Expected latency depends on PMOD_GPIO_SAMPLER_DEBOUNCE_EN.
module tb_pmod_gpio_sampler;

`ifdef PMOD_GPIO_SAMPLER_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] top_tri_i = 4'h0;
  logic [3:0] bottom_tri_i = 4'h0;
  logic [7:0] gpio_tri_i;
  logic [7:0] rise_mask = 8'h00;
  logic [7:0] fall_mask = 8'h00;
  logic [7:0] event_clr = 8'h00;
  logic [7:0] event_o;
  logic       irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] top;
    logic [3:0] bot;
    logic [7:0] rm;
    logic [7:0] fm;
    logic [7:0] clr;
    logic [7:0] gpio;
    logic [7:0] ev;
    logic       irq;
  } vec_t;

  vec_t tbl [11];

  pmod_gpio_sampler #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .top_tri_i    (top_tri_i),
    .bottom_tri_i (bottom_tri_i),
    .gpio_tri_i   (gpio_tri_i),
    .rise_mask    (rise_mask),
    .fall_mask    (fall_mask),
    .event_clr    (event_clr),
    .event_o      (event_o),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic pat(input int k);
    logic r;
    if (k >= 1 && k <= 8) r = k[0];
    else r = 1'b0;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            top   bot   rm     fm     clr    gpio   ev     irq
    tbl[0]  = '{4'h1, 4'h0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1};
    tbl[1]  = '{4'h3, 4'h0, 8'h01, 8'h00, 8'h00, 8'h03, 8'h01, 1'b1};
    tbl[2]  = '{4'h3, 4'h8, 8'h80, 8'h00, 8'h00, 8'h83, 8'h81, 1'b1};
    tbl[3]  = '{4'h3, 4'h8, 8'h00, 8'h00, 8'h80, 8'h83, 8'h01, 1'b1};
    tbl[4]  = '{4'h3, 4'h8, 8'h00, 8'h00, 8'h01, 8'h83, 8'h00, 1'b0};
    tbl[5]  = '{4'h0, 4'h8, 8'h00, 8'h03, 8'h00, 8'h80, 8'h03, 1'b1};
    tbl[6]  = '{4'hF, 4'hF, 8'hFF, 8'h00, 8'h03, 8'hFF, 8'h7F, 1'b1};
    tbl[7]  = '{4'hA, 4'h5, 8'h00, 8'hFF, 8'hFF, 8'h5A, 8'hA5, 1'b1};
    tbl[8]  = '{4'hA, 4'h5, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5, 1'b1};
    tbl[9]  = '{4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b1};
    tbl[10] = '{4'h0, 4'h0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};

    // Reset state while rst is held.
    #12;
    chk("rst_gpio", gpio_tri_i, 8'h00);
    chk("rst_event", event_o, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    chk("post_rst_gpio", gpio_tri_i, 8'h00);

    // Exact latency of top[0] rise and the following event.
    rise_mask = 8'h01;
    top_tri_i = 4'h1;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      chk("lat_gpio", gpio_tri_i, (n >= LAT) ? 8'h01 : 8'h00);
      chk("lat_event", event_o, (n >= LAT + 1) ? 8'h01 : 8'h00);
      chk("lat_irq", {7'b0, irq}, (n >= LAT + 1) ? 8'h01 : 8'h00);
    end

    // Table of steady-state vectors.
    for (int i = 0; i < 11; i++) begin
      top_tri_i    = tbl[i].top;
      bottom_tri_i = tbl[i].bot;
      rise_mask    = tbl[i].rm;
      fall_mask    = tbl[i].fm;
      event_clr    = tbl[i].clr;
      tick(1);
      event_clr = 8'h00;
      tick(LAT + 1);
      chk($sformatf("vec%0d_gpio", i), gpio_tri_i, tbl[i].gpio);
      chk($sformatf("vec%0d_event", i), event_o, tbl[i].ev);
      chk($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, tbl[i].irq});
    end

    // Set and clear on bit 2 in the same cycle: set must win.
    rise_mask = 8'h04;
    top_tri_i = 4'h4;
    tick(LAT);
    chk("coinc_pre_event", event_o, 8'h00);
    event_clr = 8'h04;
    tick(1);
    event_clr = 8'h00;
    chk("coinc_event", event_o, 8'h04);
    chk("coinc_gpio", gpio_tri_i, 8'h04);

    // Clear all, then pulse/toggle bit 7.
    event_clr = 8'hFF;
    rise_mask = 8'h00;
    fall_mask = 8'h80;
    tick(1);
    event_clr = 8'h00;
`ifdef PMOD_GPIO_SAMPLER_DEBOUNCE_EN
    bottom_tri_i = 4'h8;
    tick(3);
    bottom_tri_i = 4'h0;
    for (int n = 0; n < 12; n++) begin
      tick(1);
      chk("glitch_gpio", gpio_tri_i, 8'h04);
    end
    chk("glitch_event", event_o, 8'h00);
`else
    for (int j = 1; j <= 11; j++) begin
      bottom_tri_i[3] = pat(j);
      tick(1);
      chk("toggle_gpio7", {7'b0, gpio_tri_i[7]}, {7'b0, pat(j - 2)});
    end
    chk("toggle_event", event_o, 8'h80);
`endif

    // Reset with bit 5 mid-transition and all events set.
    fall_mask    = 8'h00;
    top_tri_i    = 4'h0;
    bottom_tri_i = 4'h0;
    tick(LAT + 2);
    rise_mask    = 8'hFF;
    top_tri_i    = 4'hF;
    bottom_tri_i = 4'hF;
    tick(LAT + 2);
    chk("all_event", event_o, 8'hFF);
    bottom_tri_i = 4'hD;
    tick(LAT - 2);
    rst = 1'b1;
    #1;
    chk("async_rst_gpio", gpio_tri_i, 8'h00);
    chk("async_rst_event", event_o, 8'h00);
    chk("async_rst_irq", {7'b0, irq}, 8'h00);
    top_tri_i    = 4'h0;
    bottom_tri_i = 4'h2;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      chk("rel_gpio", gpio_tri_i, (n >= LAT) ? 8'h20 : 8'h00);
      chk("rel_event", event_o, (n >= LAT + 1) ? 8'h20 : 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
